// File: rtl/sramlike_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding and requester owner codes.
package sramlike_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/sramlike_arbiter.sv
// Two-requester arbiter sharing one sram-like downstream port, one transaction
// outstanding, round-robin on contention.
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [ADDR_W-1:0] inst_wdata,
  output logic [ADDR_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic [ADDR_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  output logic              busy,
  output logic              owner
);

  arb_state_e r_state, w_state_nxt;
  owner_e     r_owner, w_owner_nxt;
  owner_e     r_last,  w_last_nxt;
  owner_e     w_pick;
  logic       w_other_req;

  function automatic owner_e rr_pick(input logic i_r, input logic d_r, input owner_e last);
    if (i_r && d_r) return (last == OWN_INST) ? OWN_DATA : OWN_INST;
    else if (d_r)   return OWN_DATA;
    else            return OWN_INST;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
      r_last  <= OWN_INST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_pick      = rr_pick(inst_req, data_req, r_last);
    w_other_req = (r_owner == OWN_INST) ? data_req : inst_req;
    case (r_state)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          w_state_nxt = ST_ADDR;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            // Owner's req in this cycle is the transaction just completed, so
            // only the other requester can make a back-to-back grant here.
            if (w_other_req) begin
              w_state_nxt = ST_ADDR;
              w_owner_nxt = owner_e'(~r_owner);
              w_last_nxt  = owner_e'(~r_owner);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          if (inst_req || data_req) begin
            w_state_nxt = ST_ADDR;
            w_owner_nxt = w_pick;
            w_last_nxt  = w_pick;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (r_state == ST_ADDR) begin
      mem_req = 1'b1;
      if (r_owner == OWN_INST) begin
        mem_wr       = inst_wr;
        mem_size     = inst_size;
        mem_addr     = inst_addr;
        mem_wdata    = inst_wdata;
        inst_addr_ok = mem_addr_ok;
        inst_data_ok = mem_addr_ok && mem_data_ok;
      end else begin
        mem_wr       = data_wr;
        mem_size     = data_size;
        mem_addr     = data_addr;
        mem_wdata    = data_wdata;
        data_addr_ok = mem_addr_ok;
        data_data_ok = mem_addr_ok && mem_data_ok;
      end
    end else if (r_state == ST_DATA) begin
      if (r_owner == OWN_INST) inst_data_ok = mem_data_ok;
      else                     data_data_ok = mem_data_ok;
    end
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign busy       = (r_state != ST_IDLE);
  assign owner      = r_owner;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Self-checking bench for sramlike_arbiter: cycle vector table, hand-written
// corner sequences, and a contention run with a scoreboarded slave model.
module tb_sramlike_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IWDATA = 32'h1111_1111;
  localparam logic [31:0] DWDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DADDR  = 32'h0000_0200;

  sramlike_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // exp bits: {mem_req, mem_wr, busy, owner, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [7:0]  exp;
    logic [31:0] maddr;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] rdata;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic ao, input logic dk,
                              input logic [31:0] rd, input logic [7:0] e, input logic [31:0] ma);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.aok = ao; v.dok = dk;
    v.rdata = rd; v.exp = e; v.maddr = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [31:0] ewd;
    logic [1:0]  esz;
    rst = v.rst; inst_req = v.ireq; inst_addr = v.iaddr; data_req = v.dreq;
    data_addr = DADDR; mem_addr_ok = v.aok; mem_data_ok = v.dok; mem_rdata = v.rdata;
    #4;
    ewd = v.exp[7] ? (v.exp[4] ? DWDATA : IWDATA) : 32'h0;
    esz = v.exp[7] ? 2'd2 : 2'd0;
    chk({name, ".ctl"}, {mem_req, mem_wr, busy, owner, inst_addr_ok, inst_data_ok,
                         data_addr_ok, data_data_ok}, v.exp);
    chk({name, ".bus"}, {mem_size, mem_addr, mem_wdata}, {esz, v.maddr, ewd});
    chk({name, ".rdata"}, {inst_rdata, data_rdata}, {v.rdata, v.rdata});
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned ic, dc, grants, a_cnt, d_cnt, lat, budget, dgr8;
    logic        s_busy, dok_now, ia, da, eown;
    logic [31:0] eaddr;
    sb_t         e;

    rst = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = IWDATA;
    data_wr = 1'b1; data_size = 2'd2; data_addr = DADDR; data_wdata = DWDATA;
    repeat (2) @(posedge clk);
    #1;

    // single inst read, idle data_ok, simultaneous requests after reset
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'h1FC00000,  0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'h1FC00000,  0, 0, 0, 32'h0,         8'b1010_0000, 32'h1FC00000));
    tbl.push_back(mk(0, 1, 32'h1FC00000,  0, 1, 0, 32'h0,         8'b1010_1000, 32'h1FC00000));
    tbl.push_back(mk(0, 0, 32'h1FC00000,  0, 0, 0, 32'h0,         8'b0010_0000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h1FC00000,  0, 0, 1, 32'h3C1D0000,  8'b0010_0100, 32'h0));
    tbl.push_back(mk(0, 0, 32'h1FC00000,  0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h12345678,  8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'h100,       1, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'h100,       1, 0, 0, 32'h0,         8'b1111_0000, DADDR));
    tbl.push_back(mk(0, 1, 32'h100,       1, 1, 0, 32'h0,         8'b1111_0010, DADDR));
    tbl.push_back(mk(0, 1, 32'h100,       0, 0, 0, 32'h0,         8'b0011_0000, 32'h0));
    tbl.push_back(mk(0, 1, 32'h100,       0, 0, 1, 32'hCAFEF00D,  8'b0011_0001, 32'h0));
    tbl.push_back(mk(0, 1, 32'h100,       0, 0, 0, 32'h0,         8'b1010_0000, 32'h100));
    tbl.push_back(mk(0, 1, 32'h100,       0, 1, 0, 32'h0,         8'b1010_1000, 32'h100));
    tbl.push_back(mk(0, 0, 32'h100,       0, 0, 0, 32'h0,         8'b0010_0000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h100,       0, 0, 1, 32'h0BADC0DE,  8'b0010_0100, 32'h0));
    tbl.push_back(mk(0, 0, 32'h100,       0, 0, 0, 32'h0,         8'b0000_0000, 32'h0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // reset while in DATA, then a late mem_data_ok, then a normal inst access
    apply(mk(0, 1, 32'h40, 0, 0, 0, 32'h0,       8'b0000_0000, 32'h0),  "rstdata[0]");
    apply(mk(0, 1, 32'h40, 0, 1, 0, 32'h0,       8'b1010_1000, 32'h40), "rstdata[1]");
    apply(mk(0, 0, 32'h40, 0, 0, 0, 32'h0,       8'b0010_0000, 32'h0),  "rstdata[2]");
    apply(mk(1, 0, 32'h40, 0, 0, 0, 32'h0,       8'b0010_0000, 32'h0),  "rstdata[3]");
    apply(mk(0, 0, 32'h40, 0, 0, 0, 32'h0,       8'b0000_0000, 32'h0),  "rstdata[4]");
    apply(mk(0, 0, 32'h40, 0, 0, 1, 32'h55AA55AA, 8'b0000_0000, 32'h0), "rstdata[5]");
    apply(mk(0, 1, 32'h40, 0, 0, 0, 32'h0,       8'b0000_0000, 32'h0),  "rstdata[6]");
    apply(mk(0, 1, 32'h40, 0, 1, 1, 32'h77,      8'b1010_1100, 32'h40), "rstdata[7]");
    apply(mk(0, 0, 32'h40, 0, 0, 0, 32'h0,       8'b0000_0000, 32'h0),  "rstdata[8]");

    // zero-latency slave: both acks in the same ADDR cycle, chained into the other requester
    apply(mk(0, 1, 32'h80, 0, 0, 0, 32'h0,       8'b0000_0000, 32'h0),  "zlat[0]");
    apply(mk(0, 1, 32'h80, 1, 1, 1, 32'h99,      8'b1010_1100, 32'h80), "zlat[1]");
    apply(mk(0, 0, 32'h80, 1, 1, 1, 32'hAA,      8'b1111_0011, DADDR),  "zlat[2]");
    apply(mk(0, 0, 32'h80, 0, 0, 0, 32'h0,       8'b0001_0000, 32'h0),  "zlat[3]");

    // continuous contention, 8 requests per side, random slave latencies
    rst = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    data_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ic = 0; dc = 0; grants = 0; dgr8 = 0; s_busy = 0; d_cnt = 0; budget = 0;
    a_cnt = $urandom_range(0, 2);
    while (!(ic == 8 && dc == 8 && !s_busy) && budget < 400) begin
      budget++;
      inst_req = (ic < 8); inst_addr = 32'h1000 + ic * 4;
      data_req = (dc < 8); data_addr = 32'h8000 + dc * 4;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom;
      dok_now = 0;
      if (s_busy) begin
        if (d_cnt == 0) begin
          dok_now = 1; s_busy = 0; mem_data_ok = 1; mem_rdata = sbq[0].rdata;
        end else d_cnt--;
      end
      #1;
      if (mem_req && !s_busy && !dok_now) begin
        if (a_cnt == 0) begin
          mem_addr_ok = 1;
          eown  = (grants % 2 == 0);
          eaddr = eown ? 32'h8000 + dc * 4 : 32'h1000 + ic * 4;
          chk($sformatf("grant_owner[%0d]", grants), owner, eown);
          chk($sformatf("grant_addr[%0d]", grants), mem_addr, eaddr);
          if (grants < 8 && owner) dgr8++;
          sbq.push_back('{own: eown, rdata: eaddr ^ 32'hA5A5A5A5});
          grants++;
          a_cnt = $urandom_range(0, 2);
          lat = $urandom_range(0, 2);
          if (lat == 0) begin
            dok_now = 1; mem_data_ok = 1; mem_rdata = sbq[0].rdata;
          end else begin
            s_busy = 1; d_cnt = lat - 1;
          end
        end else a_cnt--;
      end
      #2;
      if (dok_now) begin
        e = sbq.pop_front();
        chk("cont_data_ok", {inst_data_ok, data_data_ok}, e.own ? 2'b01 : 2'b10);
        chk("cont_rdata", e.own ? data_rdata : inst_rdata, e.rdata);
      end
      ia = inst_addr_ok; da = data_addr_ok;
      @(posedge clk); #1;
      if (ia) ic++;
      if (da) dc++;
    end
    chk("cont_timeout", budget < 400, 1'b1);
    chk("cont_grants", grants, 16);
    chk("cont_data_in_first8", dgr8, 4);
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    #4;
    chk("cont_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
